data_bus_adapter: RTL

- Sits between the single-cycle core's combinational data-bus port and a multi-cycle valid/ready memory or interconnect.
- Registers each core load/store and issues it as one word-aligned request with byte enables and lane-shifted write data.
- Stalls the core until the transaction completes, then returns the lane-extracted, sign/zero-extended load result.
- Detects misaligned and unsupported accesses and faults them without touching memory.

---
 rtl/data_bus_adapter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/data_bus_adapter.sv
// Bridges the single-cycle core's combinational load/store port to a multi-cycle
// valid/ready memory port: one word-aligned request per access, core stalled until done.
module data_bus_adapter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic [2:0]  core_format,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    output logic [31:0] core_data_fetched,
    output logic        core_stall,
    output logic        access_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESP, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  offset_q;
    logic [2:0]  format_q;
    logic        fault_q;
    logic        access_req;
    logic        illegal;
    logic [3:0]  store_enable;
    logic [31:0] store_data;
    logic [31:0] shifted;
    logic [31:0] load_word;

    assign access_req    = core_read_enable | core_write_enable;
    assign core_stall    = access_req & (state != DONE);
    assign mem_req_valid = (state == REQUEST);
    assign access_fault  = (state == DONE) & fault_q;

    always_comb begin
        illegal = 1'b0;
        case (core_format)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = core_address[0];
            3'b010:         illegal = |core_address[1:0];
            default:        illegal = 1'b1;
        endcase
        // Only signed/plain widths are meaningful for stores.
        if (core_write_enable && core_format[2])
            illegal = 1'b1;
    end

    always_comb begin
        store_enable = 4'b1111;
        store_data   = core_write_data;
        case (core_format[1:0])
            2'b00: begin
                store_enable = 4'b0001 << core_address[1:0];
                store_data   = {4{core_write_data[7:0]}};
            end
            2'b01: begin
                store_enable = core_address[1] ? 4'b1100 : 4'b0011;
                store_data   = {2{core_write_data[15:0]}};
            end
            default: begin
                store_enable = 4'b1111;
                store_data   = core_write_data;
            end
        endcase
    end

    assign shifted = mem_resp_data >> {offset_q, 3'b000};

    always_comb begin
        load_word = shifted;
        case (format_q)
            3'b000:  load_word = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_word = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_word = {24'd0, shifted[7:0]};
            3'b101:  load_word = {16'd0, shifted[15:0]};
            default: load_word = shifted;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (access_req) state_next = illegal ? DONE : REQUEST;
            REQUEST:   if (mem_req_ready) state_next = mem_req_write ? DONE : WAIT_RESP;
            WAIT_RESP: if (mem_resp_valid) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            offset_q          <= '0;
            format_q          <= '0;
            fault_q           <= 1'b0;
            mem_req_write     <= 1'b0;
            mem_address       <= '0;
            mem_byte_enable   <= '0;
            mem_write_data    <= '0;
            core_data_fetched <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && access_req) begin
                offset_q <= core_address[1:0];
                format_q <= core_format;
                fault_q  <= illegal;
                // Faulted accesses leave the memory-side request registers untouched.
                if (illegal) begin
                    if (!core_write_enable)
                        core_data_fetched <= '0;
                end else begin
                    mem_req_write   <= core_write_enable;
                    mem_address     <= {core_address[31:2], 2'b00};
                    mem_byte_enable <= core_write_enable ? store_enable : 4'b1111;
                    if (core_write_enable)
                        mem_write_data <= store_data;
                end
            end
            if (state == WAIT_RESP && mem_resp_valid)
                core_data_fetched <= load_word;
        end
    end

endmodule
